heap_memory: RTL



---
 rtl/heap_memory.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/heap_memory.sv
// Tagged-word heap RAM: reads, writes and two-word cons allocation behind a valid/ready port.
// Latency: READ/WRITE/error responses 1 cycle after acceptance; ALLOC responds 2 cycles after.
// Backpressure: req_ready drops for the one cycle an ALLOC spends writing its cdr; responses are never stalled.

package lisp;
    localparam int word_size = 16;
    localparam logic [word_size-1:0] TYPE_NUMBER = 16'h0001;
endpackage

module heap_memory #(
    parameter int MemSize  = 1024,
    parameter int Width    = lisp::word_size + 1,
    parameter int HeapBase = 2,
    parameter int AddrW    = $clog2(MemSize)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [AddrW-1:0] req_addr,
    input  logic [Width-1:0] req_wdata,
    input  logic [Width-1:0] req_wdata2,
    output logic             resp_valid,
    output logic [Width-1:0] resp_data,
    output logic             resp_err,
    output logic [AddrW-1:0] free_ptr
);

    localparam int IdxW = (MemSize > 1) ? $clog2(MemSize) : 1;
    // Memory size and free pointer are carried one bit wider so a power-of-two heap cannot wrap.
    localparam logic [AddrW:0]   MEM_SIZE  = (AddrW + 1)'(MemSize);
    localparam logic [AddrW:0]   HEAP_BASE = (AddrW + 1)'(HeapBase);
    localparam logic [Width-1:0] WORD0     = Width'({1'b0, lisp::TYPE_NUMBER});
    localparam logic [Width-1:0] WORD1     = Width'(16'h2A2A);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ALLOC = 2'b10;

    typedef enum logic {IDLE, CDR} state_t;

    state_t           state;
    logic [AddrW:0]   free_q;
    logic [AddrW-1:0] base_q;
    logic [Width-1:0] cdr_q;
    logic [Width-1:0] resp_data_q;
    logic [Width-1:0] rd_q;
    logic             rd_sel;

    logic             accept;
    logic             addr_ok;
    logic             heap_ok;
    logic             mem_we;
    logic             mem_re;
    logic [AddrW-1:0] mem_addr;
    logic [Width-1:0] mem_wdata;

    // Words below HeapBase hold preloaded constants; reset never touches the array.
    (* ram_style = "block" *)
    logic [Width-1:0] mem [MemSize] = '{0: WORD0, 1: WORD1, default: '0};

    assign accept    = req_valid && req_ready;
    assign addr_ok   = {1'b0, req_addr} < MEM_SIZE;
    assign heap_ok   = (free_q + (AddrW + 1)'(2)) <= MEM_SIZE;
    assign free_ptr  = free_q[AddrW-1:0];
    // Read data comes straight from the RAM output register; other responses from resp_data_q.
    assign resp_data = rd_sel ? rd_q : resp_data_q;

    // Single RAM port: the CDR write owns the port, otherwise the accepted request does.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (!rst) begin
            if (state == CDR) begin
                mem_we    = 1'b1;
                mem_addr  = base_q + AddrW'(1);
                mem_wdata = cdr_q;
            end else if (accept) begin
                case (req_op)
                    OP_READ:  mem_re = addr_ok;
                    OP_WRITE: mem_we = addr_ok;
                    OP_ALLOC: begin
                        mem_we   = heap_ok;
                        mem_addr = free_q[AddrW-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Block RAM port with registered read data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[IdxW-1:0]] <= mem_wdata;
        end
        if (mem_re) begin
            rd_q <= mem[mem_addr[IdxW-1:0]];
        end
    end

    // Request/response FSM, allocator pointer and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_data_q <= '0;
            rd_sel      <= 1'b0;
            free_q      <= HEAP_BASE;
            base_q      <= '0;
            cdr_q       <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_READ: begin
                                resp_valid <= 1'b1;
                                resp_err   <= !addr_ok;
                                rd_sel     <= addr_ok;
                                if (!addr_ok) begin
                                    resp_data_q <= '0;
                                end
                            end
                            OP_WRITE: begin
                                resp_valid  <= 1'b1;
                                resp_err    <= !addr_ok;
                                rd_sel      <= 1'b0;
                                resp_data_q <= '0;
                            end
                            OP_ALLOC: begin
                                if (heap_ok) begin
                                    state     <= CDR;
                                    req_ready <= 1'b0;
                                    base_q    <= free_q[AddrW-1:0];
                                    cdr_q     <= req_wdata2;
                                    free_q    <= free_q + (AddrW + 1)'(2);
                                end else begin
                                    resp_valid  <= 1'b1;
                                    resp_err    <= 1'b1;
                                    rd_sel      <= 1'b0;
                                    resp_data_q <= '0;
                                end
                            end
                            default: begin
                                resp_valid  <= 1'b1;
                                resp_err    <= 1'b1;
                                rd_sel      <= 1'b0;
                                resp_data_q <= '0;
                            end
                        endcase
                    end
                end
                CDR: begin
                    state       <= IDLE;
                    req_ready   <= 1'b1;
                    resp_valid  <= 1'b1;
                    rd_sel      <= 1'b0;
                    resp_data_q <= Width'(base_q);
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
